// File: rtl/pbg_pkg.sv
// -----------------------------------------------------------------------------
// pbg_pkg
// Shared definitions for the pulse burst generator.
//   pbg_state_t : burst controller state (IDLE, PULSE, GAP, DONE)
//   sat_min     : unsigned clamp used when loading the count and gap fields
// -----------------------------------------------------------------------------
package pbg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } pbg_state_t;

    // Returns the smaller of value and limit. Callers widen their operands to
    // 32 bits and cast the result back to the field width, so the function
    // serves the count and gap fields alike.
    function automatic logic [31:0] sat_min(input logic [31:0] value,
                                            input logic [31:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/pulse_burst_gen_dcnt.sv
// -----------------------------------------------------------------------------
// dcnt_load
// Loadable down counter that saturates at zero.
//   clk   in  clock, rising edge
//   aclr  in  asynchronous active-high reset (q -> 0)
//   load  in  load din into q
//   din   in  load value
//   dec   in  decrement q by one (ignored when q is already zero)
//   clr   in  synchronous clear, highest priority
//   q     out counter value
//   zero  out q == 0
// -----------------------------------------------------------------------------
module dcnt_load #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             dec,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             zero
);

    // Counter register: clear beats load beats decrement. The decrement is
    // held off at zero so the value can never wrap around.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (dec && (q != '0)) begin
            q <= q - WIDTH'(1);
        end
    end

    assign zero = (q == '0);

endmodule

// File: rtl/pulse_burst_gen.sv
// -----------------------------------------------------------------------------
// pulse_burst_gen
// Emits a burst of single-cycle pulse strobes separated by a programmable
// number of idle cycles. A command is taken over a valid/ready handshake;
// abort cancels the burst without a done strobe.
//   clk       in  clock, rising edge
//   aclr      in  asynchronous active-high reset
//   s_valid   in  command valid
//   s_ready   out command accepted when s_valid && s_ready (high in IDLE)
//   s_count   in  pulses in the burst (clamped to MAX_CNT)
//   s_gap     in  idle cycles between pulses (clamped to MAX_GAP)
//   abort     in  cancel the active burst
//   pulse     out single-cycle strobe
//   busy      out burst in progress
//   done      out one-cycle completion strobe
//   remaining out pulses still to go, including the one showing now
// All outputs are decodes of registered state.
// -----------------------------------------------------------------------------
module pulse_burst_gen
    import pbg_pkg::*;
#(
    parameter int MAX_CNT = 256,
    parameter int MAX_GAP = 16,
    parameter int CNT_W   = $clog2(MAX_CNT + 1),
    parameter int GAP_W   = $clog2(MAX_GAP + 1)
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [CNT_W-1:0] s_count,
    input  logic [GAP_W-1:0] s_gap,
    input  logic             abort,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    pbg_state_t       state;
    pbg_state_t       next_state;

    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] count_in;
    logic             rem_zero;
    logic             rem_load;
    logic             rem_dec;
    logic             rem_clr;

    logic [GAP_W-1:0] gcnt;
    logic [GAP_W-1:0] gap_r;
    logic [GAP_W-1:0] gap_in;
    logic             gcnt_zero;
    logic             gcnt_load;
    logic             gcnt_dec;

    logic             accept;

    assign accept   = s_valid && (state == IDLE);
    assign count_in = CNT_W'(sat_min(32'(s_count), 32'(MAX_CNT)));
    assign gap_in   = GAP_W'(sat_min(32'(s_gap), 32'(MAX_GAP)));

    // State register.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The gap length is captured once per command so the gap counter can be
    // reloaded from it after every pulse of the burst.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            gap_r <= '0;
        end else if (accept) begin
            gap_r <= gap_in;
        end
    end

    // Next-state and counter control. Abort outranks everything once a burst
    // is active. The zero flags are fallbacks so that a counter that somehow
    // reads zero still lets the burst terminate instead of stalling.
    always_comb begin
        next_state = state;
        rem_load   = 1'b0;
        rem_dec    = 1'b0;
        rem_clr    = 1'b0;
        gcnt_load  = 1'b0;
        gcnt_dec   = 1'b0;

        if (abort && (state != IDLE)) begin
            next_state = IDLE;
            rem_clr    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem_load   = 1'b1;
                        next_state = (count_in == '0) ? DONE : PULSE;
                    end
                end
                PULSE: begin
                    rem_dec = !rem_zero;
                    if ((rem == CNT_W'(1)) || rem_zero) begin
                        next_state = DONE;
                    end else if (gap_r == '0) begin
                        next_state = PULSE;
                    end else begin
                        next_state = GAP;
                        gcnt_load  = 1'b1;
                    end
                end
                GAP: begin
                    if ((gcnt == GAP_W'(1)) || gcnt_zero) begin
                        next_state = PULSE;
                    end else begin
                        gcnt_dec = 1'b1;
                    end
                end
                DONE: begin
                    next_state = IDLE;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    dcnt_load #(
        .WIDTH (CNT_W)
    ) u_rem (
        .clk  (clk),
        .aclr (aclr),
        .load (rem_load),
        .din  (count_in),
        .dec  (rem_dec),
        .clr  (rem_clr),
        .q    (rem),
        .zero (rem_zero)
    );

    // The gap counter stops at 1 on its way out of GAP; it is always
    // reloaded before it is used again, so it never needs clearing.
    dcnt_load #(
        .WIDTH (GAP_W)
    ) u_gcnt (
        .clk  (clk),
        .aclr (aclr),
        .load (gcnt_load),
        .din  (gap_r),
        .dec  (gcnt_dec),
        .clr  (1'b0),
        .q    (gcnt),
        .zero (gcnt_zero)
    );

    assign s_ready   = (state == IDLE);
    assign pulse     = (state == PULSE);
    assign done      = (state == DONE);
    assign busy      = (state != IDLE);
    assign remaining = rem;

endmodule

// File: doc/pulse_burst_gen.md
# pulse_burst_gen

Emits a programmed number of single-cycle `pulse` strobes, spaced a programmed number of idle cycles apart, with a valid/ready command handshake. It is the producer side of the enable input on the team's step counters: control logic issues a command here, and the strobes drive a downstream counter's `ena`. Typical uses are stepper drives, test-pattern bursts and timed enable trains.

## Interface
- `MAX_CNT`, default 256: largest pulse count per burst.
- `MAX_GAP`, default 16: largest number of idle cycles between pulses.
- `CNT_W`, default `$clog2(MAX_CNT+1)`: count width.
- `GAP_W`, default `$clog2(MAX_GAP+1)`: gap width.
- `clk`  in  1  clock; all logic is on its rising edge.
- `aclr`  in  1  reset, asynchronous, active-high.
- `s_valid`  in  1  command valid.
- `s_ready`  out  1  command accepted when `s_valid && s_ready`.
- `s_count`  in  CNT_W  number of pulses in the burst.
- `s_gap`  in  GAP_W  idle cycles between consecutive pulses.
- `abort`  in  1  cancels the active burst.
- `pulse`  out  1  single-cycle strobe.
- `busy`  out  1  burst in progress (state is not IDLE).
- `done`  out  1  one-cycle completion strobe.
- `remaining`  out  CNT_W  pulses still to be emitted, including the current one.

## Operation
- States: IDLE, PULSE, GAP, DONE.
- Outputs decoded from the state register:
  - `s_ready` = IDLE.
  - `pulse` = PULSE.
  - `done` = DONE.
  - `busy` = not IDLE.
- IDLE, on accept:
  - Load `rem` with `min(s_count, MAX_CNT)`.
  - Load `gap_r` with `min(s_gap, MAX_GAP)`.
  - If the loaded count is 0, go to DONE. Otherwise go to PULSE.
- PULSE:
  - `rem` decrements by 1.
  - If `rem == 1`, go to DONE.
  - Else if `gap_r == 0`, stay in PULSE (back-to-back pulses).
  - Else go to GAP and load `gcnt = gap_r`.
- GAP: `gcnt` decrements by 1. When `gcnt == 1`, go to PULSE.
- DONE: go to IDLE unconditionally.
- `abort` in PULSE, GAP or DONE:
  - Next state is IDLE; `rem` is cleared to 0; no `done` strobe is issued.
  - `abort` has priority over every other transition.
  - A pulse already showing in the abort cycle still counts.
  - In IDLE, `abort` is ignored.
- `s_valid` while not ready: the command is neither consumed nor latched. The sender holds it until `s_ready` is high.
- `remaining` = `rem`. All counter arithmetic is unsigned and never wraps: `rem` never goes below 0 and `gcnt` never goes below 1.

## Timing
- Reset values: state IDLE, `rem` 0, `gcnt` 0, `gap_r` 0. Hence `s_ready` 1, `pulse` 0, `busy` 0, `done` 0, `remaining` 0.
- Let the accept cycle be cycle 0, with count c ≥ 1 and gap g (both after clamping):
  - Pulses occur in cycles `1 + k*(g+1)`, for k = 0 … c-1.
  - `done` occurs in cycle `2 + (c-1)*(g+1)`.
  - `s_ready` is high again one cycle after `done`.
- c = 0: `done` in cycle 1, `s_ready` high again in cycle 2, no pulses.
- `remaining` during the k-th pulse (1-based) equals `c - k + 1`. It is 0 from the `done` cycle onward.
- `abort` sampled high in cycle n: IDLE in cycle n+1 with `s_ready` high. A new command can be accepted in cycle n+1.
- `aclr` mid-burst: immediate return to the reset values. The burst is lost and `done` is not issued.
- No combinational path from inputs to outputs. All outputs are registered state or decodes of it.

## Structure
- Shared package `pbg_pkg` holds:
  - The state enum typedef `pbg_state_t` (IDLE, PULSE, GAP, DONE).
  - A clamp function `sat_min` used for both count and gap loading.
- One sub-module, `dcnt_load`: a loadable down counter with parameter WIDTH and ports `clk`, `aclr`, `load`, `din`, `dec`, `clr`, `q`, `zero`.
- It is instantiated twice: once for `rem` (WIDTH = CNT_W) and once for `gcnt` (WIDTH = GAP_W).

## Test plan
- Reset with `aclr` pulsed → `s_ready` 1, all other outputs 0.
- Accept count=3, gap=2 in cycle 0 → pulses in cycles 1, 4, 7; `remaining` reads 3, 2, 1 at those cycles; `done` in cycle 8; `s_ready` in cycle 9.
- Accept count=4, gap=0 → pulses in cycles 1–4 back to back; `done` in cycle 5.
- Accept count=0 → no pulse; `done` in cycle 1; `s_ready` in cycle 2. Then accept count=300 with MAX_CNT=256 → exactly 256 pulses are emitted.
- Accept count=5, gap=1, with `abort` high in cycle 4 → pulses in cycles 1 and 3 only; IDLE in cycle 5 with `remaining` 0; no `done`. With `s_valid` held through cycles 2–6, the next accept happens in cycle 5 and not earlier.
- Assert `aclr` in cycle 2 of a count=3, gap=3 burst → reset values immediately; no further pulses; no `done`.
